spi_dac_rx: RTL and testbench
=============================

# spi_dac_rx

Synthesizable receiver for the 16-bit serial DAC frame that the design's DAC transmitter drives on `DAC_SDI`/`DAC_SCK`/`DAC_CS`/`DAC_LD` (MCP4911-style protocol). It oversamples the four serial lines in the 50 MHz domain, deserialises each frame, and latches the 10-bit sample and control nibble on the load strobe. It is the listening end of the DAC link: it is looped back on-chip for self-checking and stands in for the converter in board-less builds.

## Interface
Parameters:
- `FRAME_BITS`, 16: bits per frame; only 16 is supported.
- `EXP_CTRL`, 4'b0111: expected control nibble {A/B, BUF, GA, SHDN}.

Ports:
- `sysclk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `sdi`  in  1  serial data, asynchronous to `sysclk`.
- `sck`  in  1  serial clock, asynchronous to `sysclk`.
- `cs_n`  in  1  chip select, active low, asynchronous.
- `ld_n`  in  1  load strobe, active low, asynchronous.
- `dac_data`  out  10  last loaded sample (frame bits 11:2).
- `dac_ctrl`  out  4  last loaded control nibble (frame bits 15:12).
- `dac_valid`  out  1  one-cycle pulse when `dac_data`/`dac_ctrl` update.
- `frame_err`  out  1  one-cycle pulse on a malformed frame.
- `cfg_err`  out  1  one-cycle pulse on a control-nibble mismatch.

## Operation
- Input conditioning: each of `sdi`, `sck`, `cs_n`, `ld_n` passes through a 2-FF synchroniser. The synchronised `sck`, `cs_n` and `ld_n` then feed rise/fall edge detectors.
- Frame format: MSB first.
  - bit15 A/B, bit14 BUF, bit13 GA, bit12 SHDN.
  - bits 11:2 sample.
  - bits 1:0 ignored.
- 16-bit shift register `sr`, 5-bit counter `cnt` (0..17, saturating).
- States:
  - IDLE: on `cs_n` fall, clear `sr` and `cnt`, go to SHIFT.
  - SHIFT: on each `sck` rise, `sr <= {sr[14:0], sdi_sync}` and `cnt++`.
    - If `cnt` would exceed 16: pulse `frame_err`, go to DRAIN.
    - On `cs_n` rise with `cnt==16`: go to ARMED.
    - On `cs_n` rise with `cnt!=16`: pulse `frame_err`, go to IDLE.
  - DRAIN: ignore `sck`; on `cs_n` rise go to IDLE.
  - ARMED: on `ld_n` fall, load `dac_data <= sr[11:2]` and `dac_ctrl <= sr[15:12]`, pulse `dac_valid`, go to IDLE.
    - On `cs_n` fall before `ld_n`: the frame is discarded without error, and a new frame starts (clear `sr`/`cnt`, go to SHIFT).
- `ld_n` fall in IDLE, SHIFT or DRAIN: ignored; outputs keep their values.
- Simultaneous `cs_n` fall and `ld_n` fall in ARMED: the load wins, then the block goes to SHIFT in the same cycle with `sr`/`cnt` cleared.
- An `sck` rise in the same cycle as a `cs_n` rise in SHIFT is shifted first, then the count is checked.
- Outputs hold their last loaded values indefinitely. Error pulses do not alter `dac_data` or `dac_ctrl`.
- Reset mid-frame: the state machine returns to IDLE and the partial frame is lost. After `rst` releases, if `cs_n` is already low, the block waits for `cs_n` to go high, then low, before shifting.

## Timing
- Reset values:
  - `dac_data` = 0, `dac_ctrl` = 0.
  - `dac_valid`, `frame_err`, `cfg_err` = 0.
  - State IDLE, synchronisers preset to idle levels (`sck`=0, `sdi`=0, `cs_n`=1, `ld_n`=1).
- Input-to-edge latency: 3 `sysclk` cycles (2 synchroniser + 1 edge register).
- `dac_valid` asserts 4 cycles after `ld_n` falls at the pin. `dac_data`/`dac_ctrl` change in the same cycle.
- Error pulses are exactly 1 cycle wide, 4 cycles after the causing pin edge.
- Input constraints:
  - `sck` high and low phases ≥ 3 `sysclk` cycles each.
  - `sdi` stable for ≥ 3 cycles around each `sck` rise.
  - `cs_n` high ≥ 3 cycles between frames.
  - Violating these gives undefined data but never a hang.

## Configuration
- `SPI_DAC_RX_CHECK_EN` defined:
  - In ARMED, `sr[15:12]` is compared with `EXP_CTRL`.
  - On mismatch, `ld_n` fall pulses `cfg_err`, outputs are not updated and no `dac_valid` is issued, then the block goes to IDLE.
- Undefined: the nibble is loaded unchecked and `cfg_err` is tied 0.

## Structure
- Package `spi_dac_pkg`:
  - state enum (IDLE, SHIFT, DRAIN, ARMED).
  - `FRAME_BITS_C`=16.
  - Field positions: `AB_BIT`=15, `BUF_BIT`=14, `GA_BIT`=13, `SHDN_BIT`=12, `DATA_MSB`=11, `DATA_LSB`=2.
- Sub-module `sync_edge`: 2-FF synchroniser with registered `rise`/`fall` outputs, reset to a parameterised idle level. It is instantiated once per input line.

## Test plan
- Frame 0x7A5C (ctrl 0111, data 0x297), `ld_n` pulse after `cs_n` rise -> `dac_data`=0x297, `dac_ctrl`=0x7, one `dac_valid` pulse 4 cycles after the `ld_n` fall.
- 15 `sck` rises then `cs_n` rise -> `frame_err` pulse; a following `ld_n` pulse leaves outputs at their previous values.
- 17 `sck` rises -> `frame_err` pulse on the 17th; the block recovers, and the next good frame with data 0x3FF loads 0x3FF.
- With the macro, frame 0xF000 (ctrl 1111) + `ld_n` -> `cfg_err` pulse, no `dac_valid`. Without the macro -> `dac_ctrl`=0xF, `dac_data`=0x000, `dac_valid` pulse.
- `rst` asserted after 8 bits, released while `cs_n` is still low -> no load. The next complete frame of 0x7004 loads `dac_data`=0x001.
- Back-to-back frames 0x7FFC then 0x7000, each with `ld_n` -> two `dac_valid` pulses, with `dac_data` going 0x3FF then 0x000.

Source files
------------

// File: rtl/spi_dac_pkg.sv
// Shared constants for the serial DAC frame receiver: frame length, field
// positions inside the 16-bit frame and the receive state encoding.
package spi_dac_pkg;

    localparam int FRAME_BITS_C = 16;

    // Frame field positions, MSB first on the wire
    localparam int AB_BIT   = 15;
    localparam int BUF_BIT  = 14;
    localparam int GA_BIT   = 13;
    localparam int SHDN_BIT = 12;
    localparam int DATA_MSB = 11;
    localparam int DATA_LSB = 2;

    // Receive state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_ARMED = 2'd3;

endpackage

// File: rtl/spi_dac_rx_sync_edge.sv
// 2-FF synchroniser for one asynchronous line, followed by registered
// rise/fall detectors. All flops reset to the line's idle level so that
// reset release never fabricates an edge on an idle line.
module sync_edge #(
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    // Synchroniser chain plus one delay stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= IDLE_LVL;
            s2 <= IDLE_LVL;
            s3 <= IDLE_LVL;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Registered edge flags, valid 3 cycles after the pin edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
        end
    end

    // Level aligned with the edge flags
    assign level = s3;

endmodule

// File: rtl/spi_dac_rx.sv
// Receiver for the 16-bit MCP4911-style DAC frame (SDI/SCK/CS/LD).
// Oversamples the serial lines in the system clock domain, deserialises one
// frame per chip-select window and latches sample and control on the load
// strobe. Optional build macro SPI_DAC_RX_CHECK_EN enables checking of the
// control nibble against EXP_CTRL before loading.
module spi_dac_rx
    import spi_dac_pkg::*;
#(
    parameter int         FRAME_BITS = 16,
    parameter logic [3:0] EXP_CTRL   = 4'b0111
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       sdi,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       ld_n,
    output logic [9:0] dac_data,
    output logic [3:0] dac_ctrl,
    output logic       dac_valid,
    output logic       frame_err,
    output logic       cfg_err
);

`ifdef SPI_DAC_RX_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    localparam logic [4:0] FULL_CNT = 5'(FRAME_BITS);
    localparam logic [4:0] MAX_CNT  = FULL_CNT + 5'd1;

    logic sdi_lvl, sdi_rise, sdi_fall;
    logic sck_lvl, sck_rise, sck_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic ld_lvl, ld_rise, ld_fall;

    sync_edge #(.IDLE_LVL(1'b0)) u_sync_sdi (
        .clk(sysclk), .rst(rst), .din(sdi),
        .level(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall)
    );
    sync_edge #(.IDLE_LVL(1'b0)) u_sync_sck (
        .clk(sysclk), .rst(rst), .din(sck),
        .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );
    sync_edge #(.IDLE_LVL(1'b1)) u_sync_cs (
        .clk(sysclk), .rst(rst), .din(cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    sync_edge #(.IDLE_LVL(1'b1)) u_sync_ld (
        .clk(sysclk), .rst(rst), .din(ld_n),
        .level(ld_lvl), .rise(ld_rise), .fall(ld_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sdi_rise, sdi_fall, sck_lvl, sck_fall, cs_lvl, ld_lvl, ld_rise};

    logic [1:0]            state_q, state_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [2:0]            warm_q;
    logic [9:0]            data_q, data_d;
    logic [3:0]            ctrl_q, ctrl_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic                  cerr_q, cerr_d;

    logic warm_done;
    logic ctrl_ok;
    logic load_ok;

    // A CS fall seen while the synchronisers flush after reset comes from the
    // preset level, not the pin: if CS was already low we wait for high-low.
    assign warm_done = (warm_q == 3'd4);
    assign ctrl_ok   = (sr_q[AB_BIT:SHDN_BIT] == EXP_CTRL);
    assign load_ok   = !CHECK_EN || ctrl_ok;

    // Next-state, shift, load and pulse generation
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        cerr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall && warm_done) begin
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sck_rise) begin
                    sr_d  = {sr_q[FRAME_BITS-2:0], sdi_lvl};
                    cnt_d = (cnt_q >= MAX_CNT) ? MAX_CNT : cnt_q + 5'd1;
                end
                if (sck_rise && cnt_q >= FULL_CNT) begin
                    ferr_d  = 1'b1;
                    state_d = ST_DRAIN;
                end else if (cs_rise) begin
                    // Uses the post-shift count so a coincident SCK rise counts
                    if (cnt_d == FULL_CNT) begin
                        state_d = ST_ARMED;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (ld_fall) begin
                    if (load_ok) begin
                        data_d  = sr_q[DATA_MSB:DATA_LSB];
                        ctrl_d  = sr_q[AB_BIT:SHDN_BIT];
                        valid_d = 1'b1;
                    end else begin
                        cerr_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                // New frame start overrides; any coincident load used sr_q above
                if (cs_fall) begin
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            warm_q  <= '0;
            data_q  <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            cerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            warm_q  <= warm_done ? warm_q : warm_q + 3'd1;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            cerr_q  <= cerr_d;
        end
    end

    assign dac_data  = data_q;
    assign dac_ctrl  = ctrl_q;
    assign dac_valid = valid_q;
    assign frame_err = ferr_q;
    assign cfg_err   = cerr_q;

endmodule

// File: tb/tb_spi_dac_rx.sv
// Directed self-checking bench for spi_dac_rx.
module tb_spi_dac_rx;

    logic       sysclk = 1'b0;
    logic       rst    = 1'b1;
    logic       sdi    = 1'b0;
    logic       sck    = 1'b0;
    logic       cs_n   = 1'b1;
    logic       ld_n   = 1'b1;
    logic [9:0] dac_data;
    logic [3:0] dac_ctrl;
    logic       dac_valid;
    logic       frame_err;
    logic       cfg_err;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    int n_ferr   = 0;
    int n_cerr   = 0;

    spi_dac_rx #(.FRAME_BITS(16), .EXP_CTRL(4'b0111)) dut (
        .sysclk(sysclk), .rst(rst), .sdi(sdi), .sck(sck), .cs_n(cs_n), .ld_n(ld_n),
        .dac_data(dac_data), .dac_ctrl(dac_ctrl), .dac_valid(dac_valid),
        .frame_err(frame_err), .cfg_err(cfg_err)
    );

    always #10 sysclk = ~sysclk;

    // Pulse counters
    always @(posedge sysclk) begin
        if (dac_valid) n_valid <= n_valid + 1;
        if (frame_err) n_ferr  <= n_ferr + 1;
        if (cfg_err)   n_cerr  <= n_cerr + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: run exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic frame_open();
        cs_n = 1'b0;
        tick(4);
    endtask

    task automatic frame_close();
        tick(4);
        cs_n = 1'b1;
        tick(6);
    endtask

    task automatic shift_bits(input logic [15:0] word, input int n);
        for (int i = 15; i > 15 - n; i--) begin
            sdi = word[i];
            tick(4);
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
    endtask

    task automatic ld_pulse();
        ld_n = 1'b0;
        tick(4);
        ld_n = 1'b1;
        tick(6);
    endtask

    task automatic send_frame(input logic [15:0] word);
        frame_open();
        shift_bits(word, 16);
        frame_close();
        ld_pulse();
    endtask

    task automatic test_reset();
        tick(5);
        rst = 1'b0;
        tick(10);
        checks++;
        if (dac_data !== 10'h000) begin
            failures++; $display("FAIL reset_data: got %h want 000", dac_data);
        end
        checks++;
        if (dac_ctrl !== 4'h0) begin
            failures++; $display("FAIL reset_ctrl: got %h want 0", dac_ctrl);
        end
        checks++;
        if ({dac_valid, frame_err, cfg_err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_pulses: got %b want 000", {dac_valid, frame_err, cfg_err});
        end
    endtask

    task automatic test_basic_load();
        logic exp_v;
        frame_open();
        shift_bits(16'h7A5C, 16);
        frame_close();
        @(posedge sysclk); #1;
        ld_n = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge sysclk); #1;
            exp_v = (i == 4);
            checks++;
            if (dac_valid !== exp_v) begin
                failures++;
                $display("FAIL load_valid_cyc%0d: got %b want %b", i, dac_valid, exp_v);
            end
            if (i == 4) begin
                checks++;
                if (dac_data !== 10'h297 || dac_ctrl !== 4'h7) begin
                    failures++;
                    $display("FAIL load_same_cycle: got %h/%h want 297/7", dac_data, dac_ctrl);
                end
            end
        end
        ld_n = 1'b1;
        tick(6);
        checks++;
        if (n_valid !== 1) begin
            failures++; $display("FAIL load_valid_count: got %0d want 1", n_valid);
        end
    endtask

    task automatic test_short_frame();
        logic exp_e;
        int v0;
        v0 = n_valid;
        frame_open();
        shift_bits(16'hFFFF, 15);
        tick(4);
        @(posedge sysclk); #1;
        cs_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge sysclk); #1;
            exp_e = (i == 4);
            checks++;
            if (frame_err !== exp_e) begin
                failures++;
                $display("FAIL short_ferr_cyc%0d: got %b want %b", i, frame_err, exp_e);
            end
        end
        tick(4);
        ld_pulse();
        checks++;
        if (dac_data !== 10'h297 || dac_ctrl !== 4'h7 || n_valid !== v0) begin
            failures++;
            $display("FAIL short_hold: got %h/%h valids=%0d want 297/7 valids=%0d",
                     dac_data, dac_ctrl, n_valid, v0);
        end
    endtask

    task automatic test_overlong_frame();
        logic exp_e;
        int f0;
        f0 = n_ferr;
        frame_open();
        shift_bits(16'h7FFC, 16);
        sdi = 1'b1;
        tick(4);
        @(posedge sysclk); #1;
        sck = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge sysclk); #1;
            exp_e = (i == 4);
            checks++;
            if (frame_err !== exp_e) begin
                failures++;
                $display("FAIL long_ferr_cyc%0d: got %b want %b", i, frame_err, exp_e);
            end
        end
        sck = 1'b0;
        shift_bits(16'hFFFF, 2);
        frame_close();
        ld_pulse();
        checks++;
        if (n_ferr !== f0 + 1 || dac_data !== 10'h297) begin
            failures++;
            $display("FAIL long_drain: ferr=%0d data=%h want ferr=%0d data=297",
                     n_ferr, dac_data, f0 + 1);
        end
        send_frame(16'h7FFC);
        checks++;
        if (dac_data !== 10'h3FF || dac_ctrl !== 4'h7) begin
            failures++;
            $display("FAIL long_recover: got %h/%h want 3ff/7", dac_data, dac_ctrl);
        end
    endtask

    task automatic test_ctrl_check();
        int v0, c0;
        v0 = n_valid;
        c0 = n_cerr;
        send_frame(16'hF000);
`ifdef SPI_DAC_RX_CHECK_EN
        checks++;
        if (n_cerr !== c0 + 1 || n_valid !== v0) begin
            failures++;
            $display("FAIL ctrl_mismatch: cfg_err=%0d valid=%0d want %0d/%0d",
                     n_cerr, n_valid, c0 + 1, v0);
        end
        checks++;
        if (dac_data !== 10'h3FF || dac_ctrl !== 4'h7) begin
            failures++;
            $display("FAIL ctrl_hold: got %h/%h want 3ff/7", dac_data, dac_ctrl);
        end
`else
        checks++;
        if (n_cerr !== c0 || n_valid !== v0 + 1) begin
            failures++;
            $display("FAIL ctrl_unchecked: cfg_err=%0d valid=%0d want %0d/%0d",
                     n_cerr, n_valid, c0, v0 + 1);
        end
        checks++;
        if (dac_data !== 10'h000 || dac_ctrl !== 4'hF) begin
            failures++;
            $display("FAIL ctrl_load: got %h/%h want 000/f", dac_data, dac_ctrl);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = n_valid;
        send_frame(16'h7FFC);
        checks++;
        if (dac_data !== 10'h3FF) begin
            failures++; $display("FAIL b2b_first: got %h want 3ff", dac_data);
        end
        send_frame(16'h7000);
        checks++;
        if (dac_data !== 10'h000 || dac_ctrl !== 4'h7) begin
            failures++; $display("FAIL b2b_second: got %h/%h want 000/7", dac_data, dac_ctrl);
        end
        checks++;
        if (n_valid !== v0 + 2) begin
            failures++; $display("FAIL b2b_count: got %0d want %0d", n_valid, v0 + 2);
        end
    endtask

    task automatic test_reset_midframe();
        int v0, f0;
        send_frame(16'h7FFC);
        frame_open();
        shift_bits(16'h7004, 8);
        @(posedge sysclk); #1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        v0 = n_valid;
        f0 = n_ferr;
        tick(10);
        shift_bits(16'h0404, 8);
        frame_close();
        ld_pulse();
        checks++;
        if (n_valid !== v0 || n_ferr !== f0) begin
            failures++;
            $display("FAIL rst_noload: valid=%0d ferr=%0d want %0d/%0d", n_valid, n_ferr, v0, f0);
        end
        checks++;
        if (dac_data !== 10'h000 || dac_ctrl !== 4'h0) begin
            failures++; $display("FAIL rst_cleared: got %h/%h want 000/0", dac_data, dac_ctrl);
        end
        send_frame(16'h7004);
        checks++;
        if (dac_data !== 10'h001 || dac_ctrl !== 4'h7 || n_valid !== v0 + 1) begin
            failures++;
            $display("FAIL rst_next: got %h/%h valid=%0d want 001/7 valid=%0d",
                     dac_data, dac_ctrl, n_valid, v0 + 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_short_frame();
        test_overlong_frame();
        test_ctrl_check();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
